// File: rtl/mskaes_32bits_key_sched_ctrl.sv
// Key-schedule sequencer for the 32-bit masked AES-128 key datapath.
// Walks the datapath through round key 0 (or 10 when running inverse),
// then through NROUNDS S-box round trips. Each pass emits four round-key
// columns, one per cycle, to the state datapath's AddRoundKey.
// All control outputs are registered. Each is decoded from the next-state
// values, so it lines up with the cycle of the state that owns it.
module mskaes_32bits_key_sched_ctrl #(
  parameter int SBOX_LAT = 4,
  parameter int NROUNDS  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       inverse,
  output logic       busy,
  output logic       done,
  output logic       col_valid,
  output logic [1:0] col_idx,
  output logic [3:0] round_idx,
  output logic       last_round,
  output logic       sb_req,
  output logic       init,
  output logic       enable_pipe_low,
  output logic       enable_pipe_high,
  output logic       loop,
  output logic       add_from_sb,
  output logic       rcon_rst,
  output logic       rcon_update,
  output logic       rcon_inverse,
  output logic       rst_buffer_from_sbox,
  output logic       rcon_mode_256,
  output logic       rcon_mode_192,
  output logic       disable_rot_rcon,
  output logic       feedback_from_high,
  output logic       col7_toSB
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_R0   = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_UPD  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  // WAIT lasts SBOX_LAT-1 cycles, so the counter only needs to reach SBOX_LAT-2.
  localparam int              WW        = $clog2(SBOX_LAT);
  localparam logic [WW-1:0]   WAIT_LAST = WW'(SBOX_LAT - 2);
  localparam logic [3:0]      ROUNDS_L  = 4'(NROUNDS);

  typedef struct packed {
    logic       start_ready;
    logic       busy;
    logic       done;
    logic       col_valid;
    logic [1:0] col_idx;
    logic [3:0] round_idx;
    logic       last_round;
    logic       sb_req;
    logic       init;
    logic       en_low;
    logic       en_high;
    logic       loop;
    logic       add_sb;
    logic       rcon_rst;
    logic       rcon_upd;
    logic       rcon_inv;
    logic       rst_buf;
  } ctrl_t;

  logic [2:0]    state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    round_q, round_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          inv_q, inv_d;
  ctrl_t         ctrl_q, ctrl_d;

  // Maps a state and its counters to the control word the datapath needs in that state.
  function automatic ctrl_t decode_ctrl(input logic [2:0] st, input logic [1:0] col,
                                        input logic [3:0] rnd, input logic inv);
    ctrl_t c;
    c          = '0;
    c.busy     = (st != S_IDLE);
    c.rcon_inv = (st != S_IDLE) & inv;
    case (st)
      S_IDLE: c.start_ready = 1'b1;
      S_INIT: begin
        c.init     = 1'b1;
        c.en_low   = 1'b1;
        c.en_high  = 1'b1;
        c.rcon_rst = 1'b1;
        c.rst_buf  = 1'b1;
      end
      S_R0: begin
        c.loop      = 1'b1;
        c.en_low    = 1'b1;
        c.col_valid = 1'b1;
        c.col_idx   = col;
        c.round_idx = inv ? ROUNDS_L : 4'd0;
      end
      S_SEND: begin
        c.sb_req  = 1'b1;
        // Inverse mode clears the decryption buffer each round so it holds a single round.
        c.rst_buf = inv;
      end
      S_WAIT: c.en_low = 1'b0;
      S_UPD: begin
        c.en_low    = 1'b1;
        c.col_valid = 1'b1;
        c.col_idx   = col;
        c.add_sb    = (col == 2'd0);
        c.rcon_upd  = (col == 2'd3);
        c.round_idx = inv ? (ROUNDS_L - rnd) : rnd;
      end
      S_DONE: c.done = 1'b1;
      default: c.busy = 1'b1;
    endcase
    c.last_round = c.col_valid & (rnd == ROUNDS_L);
    return c;
  endfunction

  // Next-state and counter update logic.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    round_d = round_q;
    wait_d  = wait_q;
    inv_d   = inv_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          inv_d   = inverse;
          state_d = S_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        round_d = 4'd0;
        col_d   = 2'd0;
        state_d = S_R0;
      end
      S_R0: begin
        col_d   = col_q + 2'd1;
        state_d = (col_q == 2'd3) ? S_SEND : S_R0;
      end
      S_SEND: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          col_d   = 2'd0;
          round_d = (round_q == ROUNDS_L) ? round_q : (round_q + 4'd1);
          state_d = S_UPD;
        end else begin
          wait_d  = wait_q + WW'(1);
        end
      end
      S_UPD: begin
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d = (round_q == ROUNDS_L) ? S_DONE : S_SEND;
        end else begin
          state_d = S_UPD;
        end
      end
      S_DONE: begin
        col_d   = 2'd0;
        state_d = S_IDLE;
      end
      default: begin
        col_d   = 2'd0;
        round_d = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Control word for the coming cycle, decoded from next-state values.
  always_comb begin
    ctrl_d = decode_ctrl(state_d, col_d, round_d, inv_d);
  end

  // State, counters and registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= 2'd0;
      round_q <= 4'd0;
      wait_q  <= '0;
      inv_q   <= 1'b0;
      ctrl_q  <= decode_ctrl(S_IDLE, 2'd0, 4'd0, 1'b0);
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      round_q <= round_d;
      wait_q  <= wait_d;
      inv_q   <= inv_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign start_ready          = ctrl_q.start_ready;
  assign busy                 = ctrl_q.busy;
  assign done                 = ctrl_q.done;
  assign col_valid            = ctrl_q.col_valid;
  assign col_idx              = ctrl_q.col_idx;
  assign round_idx            = ctrl_q.round_idx;
  assign last_round           = ctrl_q.last_round;
  assign sb_req               = ctrl_q.sb_req;
  assign init                 = ctrl_q.init;
  assign enable_pipe_low      = ctrl_q.en_low;
  assign enable_pipe_high     = ctrl_q.en_high;
  assign loop                 = ctrl_q.loop;
  assign add_from_sb          = ctrl_q.add_sb;
  assign rcon_rst             = ctrl_q.rcon_rst;
  assign rcon_update          = ctrl_q.rcon_upd;
  assign rcon_inverse         = ctrl_q.rcon_inv;
  assign rst_buffer_from_sbox = ctrl_q.rst_buf;

  // AES-192/256 features are not used by this AES-128 schedule.
  assign rcon_mode_256        = 1'b0;
  assign rcon_mode_192        = 1'b0;
  assign disable_rot_rcon     = 1'b0;
  assign feedback_from_high   = 1'b0;
  assign col7_toSB            = 1'b0;

endmodule

// File: tb/tb_mskaes_32bits_key_sched_ctrl.sv
// Bench for the key-schedule sequencer: default instance (SBOX_LAT=4) and SBOX_LAT=6 instance.
module tb_mskaes_32bits_key_sched_ctrl;

  logic clk, rst;
  int   cyc = 0;

  // default-parameter instance
  logic a_start_valid, a_inverse, a_start_ready, a_busy, a_done, a_col_valid;
  logic [1:0] a_col_idx;
  logic [3:0] a_round_idx;
  logic a_last_round, a_sb_req, a_init, a_epl, a_eph, a_loop, a_add, a_rcon_rst;
  logic a_rcon_upd, a_rcon_inv, a_rst_buf, a_m256, a_m192, a_dis, a_fb, a_c7;

  // SBOX_LAT=6 instance
  logic b_start_valid, b_inverse, b_start_ready, b_busy, b_done, b_col_valid;
  logic [1:0] b_col_idx;
  logic [3:0] b_round_idx;
  logic b_last_round, b_sb_req, b_init, b_epl, b_eph, b_loop, b_add, b_rcon_rst;
  logic b_rcon_upd, b_rcon_inv, b_rst_buf, b_m256, b_m192, b_dis, b_fb, b_c7;

  mskaes_32bits_key_sched_ctrl dut_a (
    .clk(clk), .rst(rst), .start_valid(a_start_valid), .start_ready(a_start_ready),
    .inverse(a_inverse), .busy(a_busy), .done(a_done), .col_valid(a_col_valid),
    .col_idx(a_col_idx), .round_idx(a_round_idx), .last_round(a_last_round),
    .sb_req(a_sb_req), .init(a_init), .enable_pipe_low(a_epl), .enable_pipe_high(a_eph),
    .loop(a_loop), .add_from_sb(a_add), .rcon_rst(a_rcon_rst), .rcon_update(a_rcon_upd),
    .rcon_inverse(a_rcon_inv), .rst_buffer_from_sbox(a_rst_buf), .rcon_mode_256(a_m256),
    .rcon_mode_192(a_m192), .disable_rot_rcon(a_dis), .feedback_from_high(a_fb),
    .col7_toSB(a_c7));

  mskaes_32bits_key_sched_ctrl #(.SBOX_LAT(6), .NROUNDS(10)) dut_b (
    .clk(clk), .rst(rst), .start_valid(b_start_valid), .start_ready(b_start_ready),
    .inverse(b_inverse), .busy(b_busy), .done(b_done), .col_valid(b_col_valid),
    .col_idx(b_col_idx), .round_idx(b_round_idx), .last_round(b_last_round),
    .sb_req(b_sb_req), .init(b_init), .enable_pipe_low(b_epl), .enable_pipe_high(b_eph),
    .loop(b_loop), .add_from_sb(b_add), .rcon_rst(b_rcon_rst), .rcon_update(b_rcon_upd),
    .rcon_inverse(b_rcon_inv), .rst_buffer_from_sbox(b_rst_buf), .rcon_mode_256(b_m256),
    .rcon_mode_192(b_m192), .disable_rot_rcon(b_dis), .feedback_from_high(b_fb),
    .col7_toSB(b_c7));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int rnd;
    int col;
    int last;
  } col_exp_t;

  col_exp_t a_q[$];
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int a_lo = -1, a_hi = -1, a_prev_hi = -1, a_acc_n = 0, a_sb_n = 0, a_rb_n = 0, a_last_sb = -100;
  logic a_inv_m = 1'b0;
  int b_lo = -1, b_hi = -1, b_cols = 0, b_sb_n = 0, b_last_sb = -100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Expected column stream for a default-latency run whose INIT cycle is lo.
  task automatic push_a(input int lo, input logic inv);
    for (int r = 0; r <= 10; r++) begin
      for (int k = 0; k < 4; k++) begin
        col_exp_t e;
        e.cyc  = (r == 0) ? (lo + 1 + k) : (lo + 5 + (r - 1) * 8 + 4 + k);
        e.rnd  = inv ? (10 - r) : r;
        e.col  = k;
        e.last = (r == 10) ? 1 : 0;
        a_q.push_back(e);
      end
    end
  endtask

  // Advance one cycle, record accepts, then check both instances at the negedge.
  task automatic tick();
    logic acc_a, acc_b, inv_a;
    int c;
    logic exp_busy_a, exp_busy_b;
    col_exp_t e;
    acc_a = (a_start_valid === 1'b1) && (a_start_ready === 1'b1) && (rst === 1'b0);
    acc_b = (b_start_valid === 1'b1) && (b_start_ready === 1'b1) && (rst === 1'b0);
    inv_a = a_inverse;
    @(negedge clk);
    c = cyc;
    if (acc_a) begin
      a_prev_hi = a_hi;
      a_lo = c; a_hi = c + 85; a_inv_m = inv_a;
      a_acc_n++; a_sb_n = 0; a_rb_n = 0;
      push_a(c, inv_a);
    end
    if (acc_b) begin
      b_lo = c; b_hi = c + 105; b_cols = 0; b_sb_n = 0;
    end
    // instance A
    exp_busy_a = (c >= a_lo) && (c <= a_hi);
    chk("a_busy", a_busy, exp_busy_a);
    chk("a_start_ready", a_start_ready, !exp_busy_a);
    chk("a_done", a_done, (c == a_hi));
    chk("a_enable_pipe_high", a_eph, (c == a_lo));
    chk("a_rcon_inverse", a_rcon_inv, exp_busy_a & a_inv_m);
    chk("a_tied_zero", {a_m256, a_m192, a_dis, a_fb, a_c7}, 5'd0);
    if (a_sb_req === 1'b1) begin a_sb_n++; a_last_sb = c; end
    if (a_rst_buf === 1'b1) a_rb_n++;
    if (a_add === 1'b1) chk("a_sb_to_add_gap", c - a_last_sb, 4);
    if (a_col_valid === 1'b1) begin
      if (a_q.size() > 0) begin
        e = a_q.pop_front();
        chk("a_col_cycle", c, e.cyc);
        chk("a_round_idx", a_round_idx, e.rnd);
        chk("a_col_idx", a_col_idx, e.col);
        chk("a_last_round", a_last_round, e.last);
      end else begin
        chk("a_col_extra", a_col_valid, 1'b0);
      end
    end
    if (c == a_hi) begin
      chk("a_cols_left", a_q.size(), 0);
      chk("a_sb_req_count", a_sb_n, 10);
      chk("a_rst_buf_count", a_rb_n, a_inv_m ? 11 : 1);
    end
    // instance B
    exp_busy_b = (c >= b_lo) && (c <= b_hi);
    chk("b_busy", b_busy, exp_busy_b);
    chk("b_done", b_done, (c == b_hi));
    chk("b_tied_zero", {b_m256, b_m192, b_dis, b_fb, b_c7}, 5'd0);
    if (b_sb_req === 1'b1) begin b_sb_n++; b_last_sb = c; end
    if (b_col_valid === 1'b1) b_cols++;
    if (b_add === 1'b1) chk("b_sb_to_add_gap", c - b_last_sb, 6);
    if (c == b_hi) begin
      chk("b_col_count", b_cols, 44);
      chk("b_sb_req_count", b_sb_n, 10);
    end
  endtask

  initial begin
    logic found;
    rst = 1'b1;
    a_start_valid = 1'b0; a_inverse = 1'b0;
    b_start_valid = 1'b0; b_inverse = 1'b0;
    repeat (3) tick();
    chk("reset_a_start_ready", a_start_ready, 1'b1);
    chk("reset_a_round_idx", a_round_idx, 4'd0);
    chk("reset_b_start_ready", b_start_ready, 1'b1);
    rst = 1'b0;
    tick();

    // forward run on the default instance
    a_start_valid = 1'b1; a_inverse = 1'b0;
    tick();
    a_start_valid = 1'b0;
    repeat (90) tick();

    // inverse run
    a_start_valid = 1'b1; a_inverse = 1'b1;
    tick();
    a_start_valid = 1'b0; a_inverse = 1'b0;
    repeat (90) tick();

    // longer S-box latency
    b_start_valid = 1'b1;
    tick();
    b_start_valid = 1'b0;
    repeat (110) tick();

    // start held high across a whole run: one schedule, next accepted right after done
    a_acc_n = 0;
    a_start_valid = 1'b1;
    repeat (100) tick();
    a_start_valid = 1'b0;
    repeat (90) tick();
    chk("a_accept_count_held", a_acc_n, 2);
    chk("a_back_to_back_gap", a_lo - a_prev_hi, 2);

    // reset during UPD of round 5
    a_start_valid = 1'b1;
    tick();
    a_start_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (a_col_valid === 1'b1 && a_loop === 1'b0 && a_round_idx === 4'd5) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("a_reached_round5", found, 1'b1);
    rst = 1'b1;
    a_lo = -1; a_hi = -1;
    a_q.delete();
    tick();
    rst = 1'b0;
    chk("midrst_start_ready", a_start_ready, 1'b1);
    chk("midrst_busy", a_busy, 1'b0);
    chk("midrst_col_valid", a_col_valid, 1'b0);
    chk("midrst_done", a_done, 1'b0);
    repeat (20) tick();
    chk("midrst_idle_after", a_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
